// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: WIDTH-bit carry chain split into STAGES
// registered segments, valid/ready on both sides, sideband tag kept aligned.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic             w_adv;
  logic [WIDTH-1:0] w_bp;
  logic             w_cin0;

  // Per-stage inputs (from the ports for stage 0, from the previous register otherwise)
  logic [WIDTH-1:0] w_a_in  [STAGES];
  logic [WIDTH-1:0] w_b_in  [STAGES];
  logic [WIDTH-1:0] w_ps_in [STAGES];
  logic             w_c_in  [STAGES];
  logic             w_v_in  [STAGES];
  logic [TAG_W-1:0] w_t_in  [STAGES];

  // Per-stage results to be registered
  logic [WIDTH-1:0] w_ps_nx [STAGES];
  logic             w_c_nx  [STAGES];

  // Stage registers; operands travel with their partial sum so each
  // segment adds bits belonging to the same operation as its carry.
  logic             r_vld [STAGES];
  logic [TAG_W-1:0] r_tag [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic             r_cy  [STAGES];

  // Whole pipe moves as one; a stalled head freezes every stage
  assign w_adv    = !r_vld[LAST] || out_ready;
  assign in_ready = w_adv;

  // Subtraction is a + ~b + 1
  assign w_bp   = sub ? ~b : b;
  assign w_cin0 = sub | carry_in;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SEG{1'b1}}) << (s * SEG);
    logic [SEG:0] w_seg;

    if (s == 0) begin : g_head
      assign w_a_in[s]  = a;
      assign w_b_in[s]  = w_bp;
      assign w_ps_in[s] = '0;
      assign w_c_in[s]  = w_cin0;
      assign w_v_in[s]  = in_valid;
      assign w_t_in[s]  = tag_in;
    end else begin : g_body
      assign w_a_in[s]  = r_a[s-1];
      assign w_b_in[s]  = r_b[s-1];
      assign w_ps_in[s] = r_sum[s-1];
      assign w_c_in[s]  = r_cy[s-1];
      assign w_v_in[s]  = r_vld[s-1];
      assign w_t_in[s]  = r_tag[s-1];
    end

    // Segment add with carry from the previous segment of the same operation
    assign w_seg = (SEG+1)'(w_a_in[s][s*SEG +: SEG])
                 + (SEG+1)'(w_b_in[s][s*SEG +: SEG])
                 + (SEG+1)'(w_c_in[s]);

    // Splice this segment's sum into the partial result carried along
    assign w_ps_nx[s] = (w_ps_in[s] & ~MASK) | ((WIDTH'(w_seg[SEG-1:0])) << (s * SEG));
    assign w_c_nx[s]  = w_seg[SEG];
  end

  // Stage registers: shift together on advance, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_vld[s] <= 1'b0;
        r_tag[s] <= '0;
        r_a[s]   <= '0;
        r_b[s]   <= '0;
        r_sum[s] <= '0;
        r_cy[s]  <= 1'b0;
      end
    end else if (w_adv) begin
      for (int s = 0; s < STAGES; s++) begin
        r_vld[s] <= w_v_in[s];
        r_tag[s] <= w_t_in[s];
        r_a[s]   <= w_a_in[s];
        r_b[s]   <= w_b_in[s];
        r_sum[s] <= w_ps_nx[s];
        r_cy[s]  <= w_c_nx[s];
      end
    end
  end

  assign out_valid = r_vld[LAST];
  assign sum       = r_sum[LAST];
  assign carry_out = r_cy[LAST];
  assign tag_out   = r_tag[LAST];
  // Signed overflow from the final stage's operand MSBs (B already inverted) and sum MSB
  assign overflow  = (r_a[LAST][WIDTH-1] == r_b[LAST][WIDTH-1])
                  && (r_sum[LAST][WIDTH-1] != r_a[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed cases, random streaming,
// backpressure and mid-flight reset against a plain-arithmetic reference.
module tb_pipelined_adder;

  typedef logic [21:0] res_t;  // {carry_out, overflow, tag, sum}

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic        sub;
  logic [3:0]  tag_in;
  logic        out_ready;

  logic        in_ready4, out_valid4, carry_out4, overflow4;
  logic [15:0] sum4;
  logic [3:0]  tag_out4;
  logic        in_ready1, out_valid1, carry_out1, overflow1;
  logic [15:0] sum1;
  logic [3:0]  tag_out1;
  logic        in_ready16, out_valid16, carry_out16, overflow16;
  logic [15:0] sum16;
  logic [3:0]  tag_out16;

  int   checks;
  int   failures;
  int   out_cnt;
  int   stall_cnt;
  res_t exp_q[$];
  logic prev_stall;
  res_t held;
  logic accepted;
  res_t obs4, obs1, obs16;
  logic ov4s, ov1s, ov16s, rdy4s;

  pipelined_adder #(.WIDTH(16), .STAGES(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub), .tag_in(tag_in),
    .out_valid(out_valid4), .out_ready(out_ready), .sum(sum4),
    .carry_out(carry_out4), .overflow(overflow4), .tag_out(tag_out4));

  pipelined_adder #(.WIDTH(16), .STAGES(1), .TAG_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub), .tag_in(tag_in),
    .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1),
    .carry_out(carry_out1), .overflow(overflow1), .tag_out(tag_out1));

  pipelined_adder #(.WIDTH(16), .STAGES(16), .TAG_W(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub), .tag_in(tag_in),
    .out_valid(out_valid16), .out_ready(out_ready), .sum(sum16),
    .carry_out(carry_out16), .overflow(overflow16), .tag_out(tag_out16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic for {cout,sum}, signed range test for overflow
  function automatic res_t model(input logic [15:0] fa, input logic [15:0] fb,
                                 input logic fs, input logic fc, input logic [3:0] ft);
    int unsigned full;
    int          sa, sb, sres;
    logic [16:0] f17;
    logic        fov;
    sa = int'($signed(fa));
    sb = int'($signed(fb));
    if (fs) begin
      full = 32'(fa) + (32'd65536 - 32'(fb));
      sres = sa - sb;
    end else begin
      full = 32'(fa) + 32'(fb) + 32'(fc);
      sres = sa + sb + int'(fc);
    end
    f17 = full[16:0];
    fov = (sres > 32767) || (sres < -32768);
    return {f17[16], fov, ft, f17[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, o, e);
    end
  endtask

  task automatic rand_ops();
    a        = 16'($urandom);
    b        = 16'($urandom);
    sub      = 1'($urandom);
    carry_in = 1'($urandom);
  endtask

  // One clock: sample at the falling edge, score transfers, then advance
  task automatic tick();
    #1;
    obs4  = {carry_out4, overflow4, tag_out4, sum4};
    obs1  = {carry_out1, overflow1, tag_out1, sum1};
    obs16 = {carry_out16, overflow16, tag_out16, sum16};
    ov4s  = out_valid4;
    ov1s  = out_valid1;
    ov16s = out_valid16;
    rdy4s = in_ready4;
    chk("in_ready_rule", 32'(in_ready4), 32'(!(out_valid4 && !out_ready)));
    if (prev_stall)
      chk("stall_hold", 32'({out_valid4, obs4}), 32'({1'b1, held}));
    if (exp_q.size() == 0)
      chk("no_stale_out", 32'(out_valid4), 32'(0));
    else if (out_valid4 && out_ready)
      chk("result", 32'(obs4), 32'(exp_q.pop_front()));
    if (out_valid4 && out_ready) out_cnt++;
    prev_stall = out_valid4 && !out_ready;
    if (prev_stall) stall_cnt++;
    held     = obs4;
    accepted = in_valid && in_ready4;
    if (accepted) exp_q.push_back(model(a, b, sub, carry_in, tag_in));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single operation with fixed expected result and latency
  task automatic single_op(input string name, input logic [15:0] fa, input logic [15:0] fb,
                           input logic fs, input logic fc, input logic [3:0] ft, input res_t e);
    int lat;
    lat = 0;
    a = fa; b = fb; sub = fs; carry_in = fc; tag_in = ft; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      tick();
      if (ov4s) begin
        lat = n;
        chk({name, "_val"}, 32'(obs4), 32'(e));
      end
    end
    chk({name, "_lat"}, 32'(lat), 32'(4));
  endtask

  initial begin
    int   base;
    int   j;
    int   lat4, lat1, lat16;
    res_t e;

    checks = 0; failures = 0; out_cnt = 0; stall_cnt = 0;
    prev_stall = 1'b0; held = '0; accepted = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    carry_in = 1'b0; sub = 1'b0; tag_in = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid4), 32'(0));
    chk("rst_sum",       32'(sum4),       32'(0));
    chk("rst_carry_out", 32'(carry_out4), 32'(0));
    chk("rst_overflow",  32'(overflow4),  32'(0));
    chk("rst_tag_out",   32'(tag_out4),   32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready4), 32'(1));

    // Directed arithmetic cases
    single_op("t1_add",     16'h1234, 16'h0001, 1'b0, 1'b0, 4'd3, {1'b0, 1'b0, 4'd3, 16'h1235});
    single_op("t2_ripple",  16'hFFFF, 16'h0000, 1'b0, 1'b1, 4'd1, {1'b1, 1'b0, 4'd1, 16'h0000});
    single_op("t2_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd2, {1'b0, 1'b1, 4'd2, 16'h8000});
    single_op("t3_sub",     16'h0005, 16'h0007, 1'b1, 1'b1, 4'd4, {1'b0, 1'b0, 4'd4, 16'hFFFE});
    single_op("t3_sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 4'd5, {1'b1, 1'b1, 4'd5, 16'h7FFF});

    // Back-to-back random stream
    base = out_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_ops();
      tag_in = 4'($urandom);
      tick();
      chk("t4_in_ready", 32'(rdy4s), 32'(1));
      if (i >= 4) chk("t4_one_per_cycle", 32'(ov4s), 32'(1));
    end
    in_valid = 1'b0;
    repeat (8) tick();
    chk("t4_count",   32'(out_cnt - base),  32'(100));
    chk("t4_drained", 32'(exp_q.size()),    32'(0));

    // Backpressure with out_ready pattern 1,0,0 repeating
    base = out_cnt;
    stall_cnt = 0;
    j = 0;
    for (int c = 0; c < 200 && (j < 8 || out_cnt - base < 8); c++) begin
      out_ready = (c % 3 == 0);
      if (j < 8) begin
        in_valid = 1'b1;
        rand_ops();
        tag_in = 4'(j);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (accepted) j++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t5_accepted",    32'(j),                  32'(8));
    chk("t5_count",       32'(out_cnt - base),     32'(8));
    chk("t5_drained",     32'(exp_q.size()),       32'(0));
    chk("t5_stalls_seen", 32'(stall_cnt > 0),      32'(1));

    // Reset with operations in flight
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      rand_ops();
      tag_in = 4'(k + 9);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid4", 32'(out_valid4),  32'(0));
    chk("t6_rst_sum4",   32'(sum4),        32'(0));
    chk("t6_rst_tag4",   32'(tag_out4),    32'(0));
    chk("t6_rst_valid1", 32'(out_valid1),  32'(0));
    chk("t6_rst_sum1",   32'(sum1),        32'(0));
    chk("t6_rst_tag1",   32'(tag_out1),    32'(0));
    chk("t6_rst_valid16", 32'(out_valid16), 32'(0));
    chk("t6_rst_sum16",  32'(sum16),       32'(0));
    chk("t6_rst_tag16",  32'(tag_out16),   32'(0));
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      chk("t6_no_stale1",  32'(ov1s),  32'(0));
      chk("t6_no_stale16", 32'(ov16s), 32'(0));
    end

    // Post-reset latency for STAGES = 4, 1 and 16
    rand_ops();
    tag_in = 4'd6;
    e = model(a, b, sub, carry_in, tag_in);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat4 = 0; lat1 = 0; lat16 = 0;
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (ov4s && lat4 == 0) lat4 = n;
      if (ov1s && lat1 == 0) begin
        lat1 = n;
        chk("t6_val1", 32'(obs1), 32'(e));
      end
      if (ov16s && lat16 == 0) begin
        lat16 = n;
        chk("t6_val16", 32'(obs16), 32'(e));
      end
    end
    chk("t6_lat4",  32'(lat4),  32'(4));
    chk("t6_lat1",  32'(lat1),  32'(1));
    chk("t6_lat16", 32'(lat16), 32'(16));
    chk("t6_drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
